// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache refill controller: FSM state
// encoding, address field positions (tag/index/offset) and access-size codes.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRefill = 3'd1,
        StFill   = 3'd2,
        StResp   = 3'd3,
        StWrite  = 3'd4
    } state_e;

    // Byte-address field positions for the default geometry.
    localparam int unsigned TagMsb = 15;
    localparam int unsigned TagLsb = 8;
    localparam int unsigned IdxMsb = 7;
    localparam int unsigned IdxLsb = 4;
    localparam int unsigned OffMsb = 3;
    localparam int unsigned OffLsb = 2;
    localparam int unsigned OffW   = OffMsb - OffLsb + 1;

    // dataType / mem_size encodings.
    localparam logic [1:0] DtWord = 2'b00;
    localparam logic [1:0] DtByte = 2'b01;
    localparam logic [1:0] DtHalf = 2'b10;
    localparam logic [1:0] DtRsvd = 2'b11;

    // The reserved size code behaves as a full word.
    function automatic logic [1:0] norm_size(input logic [1:0] dt);
        logic [1:0] size;
        case (dt)
            DtByte:  size = DtByte;
            DtHalf:  size = DtHalf;
            default: size = DtWord;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of CPU, cache-storage, memory and perf-counter signals around the
// refill controller. The controller uses the slave modport; its environment
// (CPU, tag/data arrays, memory) uses master.
interface cache_refill_ctrl_if #(
    parameter int unsigned RAM_ADDRESS_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned CACHE_ADDRESS_WIDTH = 4,
    parameter int unsigned LINE_WORDS          = 4
);
    // CPU side
    logic                                req_valid;
    logic                                req_we;
    logic [RAM_ADDRESS_WIDTH-1:0]        A;
    logic [DATA_WIDTH-1:0]               WD;
    logic [1:0]                          dataType;
    logic                                stall;
    logic [DATA_WIDTH-1:0]               RD;
    logic                                rd_valid;
    // Cache storage side
    logic                                cache_hit;
    logic [DATA_WIDTH-1:0]               cache_rd;
    logic                                fill_we;
    logic [CACHE_ADDRESS_WIDTH-1:0]      fill_idx;
    logic [RAM_ADDRESS_WIDTH-CACHE_ADDRESS_WIDTH-5:0] fill_tag;
    logic [DATA_WIDTH*LINE_WORDS-1:0]    fill_line;
    logic                                upd_we;
    // Memory side
    logic                                mem_req;
    logic                                mem_we;
    logic [RAM_ADDRESS_WIDTH-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]               mem_wd;
    logic [1:0]                          mem_size;
    logic                                mem_ack;
    logic                                mem_rvalid;
    logic [DATA_WIDTH-1:0]               mem_rdata;
    // Perf counters
    logic [15:0]                         hit_cnt;
    logic [15:0]                         miss_cnt;

    modport slave (
        input  req_valid, req_we, A, WD, dataType, cache_hit, cache_rd,
               mem_ack, mem_rvalid, mem_rdata,
        output stall, RD, rd_valid, fill_we, fill_idx, fill_tag, fill_line, upd_we,
               mem_req, mem_we, mem_addr, mem_wd, mem_size, hit_cnt, miss_cnt
    );

    modport master (
        output req_valid, req_we, A, WD, dataType, cache_hit, cache_rd,
               mem_ack, mem_rvalid, mem_rdata,
        input  stall, RD, rd_valid, fill_we, fill_idx, fill_tag, fill_line, upd_we,
               mem_req, mem_we, mem_addr, mem_wd, mem_size, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/line_buffer.sv
// Line assembly buffer: collects refill beats by index, offers a single-word
// read port and the whole line as one flat vector (word k at bits [DW*k +: DW]).
module line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IdxW      = $clog2(LINE_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we_i,
    input  logic [IdxW-1:0]                  idx_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [IdxW-1:0]                  ridx_i,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic [DATA_WIDTH*LINE_WORDS-1:0] line_o
);
    logic [DATA_WIDTH-1:0] mem_q [LINE_WORDS];

    // Word storage: cleared by reset, one word written per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Flatten the line and select the requested word.
    always_comb begin
        line_o = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            line_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
        end
        rdata_o = mem_q[ridx_i];
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Blocking cache controller: 1-cycle read hits, 4-beat line refill on read
// miss, write-through without allocate on writes.
// Optional feature macro: CACHE_CRIT_WORD_FIRST_EN -- refill starts at the
// requested word, wraps, and forwards it to the CPU on the first beat.
module cache_refill_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned RAM_ADDRESS_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned CACHE_ADDRESS_WIDTH = 4,
    parameter int unsigned LINE_WORDS          = 4
) (
    input logic                clk,
    input logic                rst,
    cache_refill_ctrl_if.slave bus
);
    localparam int unsigned AW = RAM_ADDRESS_WIDTH;

    state_e                           state_q, state_d;
    logic [AW-1:0]                    addr_q, addr_d;
    logic [OffW-1:0]                  beat_q, beat_d;
    logic [OffW-1:0]                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]            rd_q, rd_d;
    logic                             rd_valid_q, rd_valid_d;
    logic [15:0]                      hit_q, hit_d;
    logic [15:0]                      miss_q, miss_d;

    logic                             lb_we;
    logic [DATA_WIDTH-1:0]            lb_rdata;
    logic [DATA_WIDTH*LINE_WORDS-1:0] lb_line;
    logic                             crit_fwd;
    logic [OffW-1:0]                  start_beat;
    logic [CACHE_ADDRESS_WIDTH-1:0]   idx;

`ifdef CACHE_CRIT_WORD_FIRST_EN
    assign start_beat = bus.A[OffMsb:OffLsb];
`else
    assign start_beat = '0;
`endif

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .we_i    (lb_we),
        .idx_i   (beat_q),
        .wdata_i (bus.mem_rdata),
        .ridx_i  (addr_q[OffMsb:OffLsb]),
        .rdata_o (lb_rdata),
        .line_o  (lb_line)
    );

    assign idx           = addr_q[IdxMsb:IdxLsb];
    assign bus.fill_idx  = idx;
    assign bus.fill_tag  = addr_q[TagMsb:TagLsb];
    assign bus.fill_line = lb_line;
    assign bus.RD        = crit_fwd ? bus.mem_rdata : rd_q;
    assign bus.rd_valid  = rd_valid_q | crit_fwd;
    assign bus.hit_cnt   = hit_q;
    assign bus.miss_cnt  = miss_q;

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    // Next-state logic and per-state bus outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        rd_valid_d   = 1'b0;
        hit_d        = hit_q;
        miss_d       = miss_q;
        lb_we        = 1'b0;
        crit_fwd     = 1'b0;
        bus.stall    = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        bus.mem_size = DtWord;
        bus.fill_we  = 1'b0;
        bus.upd_we   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        bus.stall = 1'b1;
                        addr_d    = bus.A;
                        state_d   = StWrite;
                    end else if (bus.cache_hit) begin
                        rd_d       = bus.cache_rd;
                        rd_valid_d = 1'b1;
                        hit_d      = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
                    end else begin
                        bus.stall = 1'b1;
                        addr_d    = bus.A;
                        beat_d    = start_beat;
                        cnt_d     = '0;
                        miss_d    = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                        state_d   = StRefill;
                    end
                end
            end
            StRefill: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q[AW-1:IdxLsb], beat_q, {OffLsb{1'b0}}};
                if (bus.mem_rvalid) begin
                    lb_we  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
`ifdef CACHE_CRIT_WORD_FIRST_EN
                    // First beat is the requested word: hand it straight through.
                    crit_fwd = (cnt_q == '0);
`endif
                    if (cnt_q == OffW'(LINE_WORDS - 1)) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                bus.stall   = 1'b1;
                bus.fill_we = 1'b1;
`ifndef CACHE_CRIT_WORD_FIRST_EN
                // Register the requested word so it appears together with RESP.
                rd_d       = lb_rdata;
                rd_valid_d = 1'b1;
`endif
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            StWrite: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = {addr_q[AW-1:OffLsb], {OffLsb{1'b0}}};
                bus.mem_wd   = bus.WD;
                bus.mem_size = norm_size(bus.dataType);
                if (bus.mem_ack) begin
                    bus.upd_we = bus.cache_hit;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed and randomized read
// hits, read misses, write-throughs, reset during refill and stray memory
// handshakes, checked against a transaction-level model of the controller.
module tb_cache_refill_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    cache_refill_ctrl_if bus_if ();

    cache_refill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.A          = '0;
        bus_if.WD         = '0;
        bus_if.dataType   = 2'b00;
        bus_if.cache_hit  = 1'b0;
        bus_if.cache_rd   = '0;
        bus_if.mem_ack    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        #1;
        checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus_if.stall); end
        checks++; if (bus_if.rd_valid !== 1'b0 || bus_if.RD !== 32'h0) begin errors++; $display("FAIL reset_rd: got rv=%b RD=%h want 0/0", bus_if.rd_valid, bus_if.RD); end
        checks++; if (bus_if.hit_cnt !== 16'h0 || bus_if.miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", bus_if.hit_cnt, bus_if.miss_cnt); end
        checks++; if (bus_if.mem_req !== 1'b0 || bus_if.fill_we !== 1'b0 || bus_if.upd_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got req=%b fill=%b upd=%b want 0", bus_if.mem_req, bus_if.fill_we, bus_if.upd_we); end
        checks++; if (bus_if.fill_line !== 128'h0) begin errors++; $display("FAIL reset_line: got %h want 0", bus_if.fill_line); end
    endtask

    task automatic test_read_hit(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.A = addr;
        bus_if.cache_hit = 1'b1; bus_if.cache_rd = data;
        #1;
        checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b want 0", bus_if.stall); end
        if (exp_hits < 65535) exp_hits++;
        @(negedge clk);
        bus_if.req_valid = 1'b0; bus_if.cache_hit = 1'b0; bus_if.cache_rd = $urandom;
        #1;
        checks++; if (bus_if.rd_valid !== 1'b1 || bus_if.RD !== data) begin errors++; $display("FAIL hit_data: got rv=%b RD=%h want 1/%h", bus_if.rd_valid, bus_if.RD, data); end
        checks++; if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL hit_stall_after: got %b want 0", bus_if.stall); end
        checks++; if (bus_if.hit_cnt !== 16'(exp_hits)) begin errors++; $display("FAIL hit_cnt: got %0d want %0d", bus_if.hit_cnt, exp_hits); end
        @(negedge clk); #1;
        checks++; if (bus_if.rd_valid !== 1'b0) begin errors++; $display("FAIL hit_pulse: got rv=%b want 0", bus_if.rd_valid); end
    endtask

    task automatic test_read_miss(input logic [15:0] addr, input logic [31:0] w0,
                                  input logic [31:0] w1, input logic [31:0] w2,
                                  input logic [31:0] w3, input int max_gap);
        logic [31:0]  beats [4];
        logic [15:0]  exp_addr;
        logic [127:0] exp_line;
        int           start;
        int           w;
        int           gap;
        logic         exp_fwd;
        beats = '{w0, w1, w2, w3};
        exp_line = {w3, w2, w1, w0};
`ifdef CACHE_CRIT_WORD_FIRST_EN
        start = int'(addr[3:2]);
`else
        start = 0;
`endif
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.A = addr; bus_if.cache_hit = 1'b0;
        #1;
        checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL miss_stall_entry: got %b want 1", bus_if.stall); end
        if (exp_misses < 65535) exp_misses++;
        for (int k = 0; k < 4; k++) begin
            w = (start + k) % 4;
            exp_addr = (addr & 16'hFFF0) | 16'(w * 4);
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus_if.mem_rvalid = 1'b0;
                #1;
                checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b0 || bus_if.mem_addr !== exp_addr) begin errors++; $display("FAIL refill_wait: got req=%b we=%b addr=%h want 1/0/%h", bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, exp_addr); end
            end
            @(negedge clk);
            bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = beats[w];
            #1;
            checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== exp_addr) begin errors++; $display("FAIL beat_addr: got req=%b addr=%h want 1/%h", bus_if.mem_req, bus_if.mem_addr, exp_addr); end
            checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL beat_stall: got %b want 1", bus_if.stall); end
`ifdef CACHE_CRIT_WORD_FIRST_EN
            exp_fwd = (k == 0);
`else
            exp_fwd = 1'b0;
`endif
            checks++; if (bus_if.rd_valid !== exp_fwd) begin errors++; $display("FAIL beat_rd_valid: got %b want %b", bus_if.rd_valid, exp_fwd); end
            if (exp_fwd) begin
                checks++; if (bus_if.RD !== beats[addr[3:2]]) begin errors++; $display("FAIL crit_word: got %h want %h", bus_if.RD, beats[addr[3:2]]); end
            end
        end
        @(negedge clk);
        bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = $urandom;
        #1;
        checks++; if (bus_if.fill_we !== 1'b1 || bus_if.stall !== 1'b1) begin errors++; $display("FAIL fill_we: got we=%b stall=%b want 1/1", bus_if.fill_we, bus_if.stall); end
        checks++; if (bus_if.fill_idx !== addr[7:4] || bus_if.fill_tag !== addr[15:8]) begin errors++; $display("FAIL fill_idx_tag: got %h/%h want %h/%h", bus_if.fill_idx, bus_if.fill_tag, addr[7:4], addr[15:8]); end
        checks++; if (bus_if.fill_line !== exp_line) begin errors++; $display("FAIL fill_line: got %h want %h", bus_if.fill_line, exp_line); end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        #1;
        checks++; if (bus_if.fill_we !== 1'b0 || bus_if.stall !== 1'b0) begin errors++; $display("FAIL resp_state: got fill=%b stall=%b want 0/0", bus_if.fill_we, bus_if.stall); end
`ifdef CACHE_CRIT_WORD_FIRST_EN
        checks++; if (bus_if.rd_valid !== 1'b0) begin errors++; $display("FAIL resp_rv: got %b want 0", bus_if.rd_valid); end
`else
        checks++; if (bus_if.rd_valid !== 1'b1 || bus_if.RD !== beats[addr[3:2]]) begin errors++; $display("FAIL resp_data: got rv=%b RD=%h want 1/%h", bus_if.rd_valid, bus_if.RD, beats[addr[3:2]]); end
`endif
        checks++; if (bus_if.miss_cnt !== 16'(exp_misses) || bus_if.hit_cnt !== 16'(exp_hits)) begin errors++; $display("FAIL miss_cnt: got %0d/%0d want %0d/%0d", bus_if.miss_cnt, bus_if.hit_cnt, exp_misses, exp_hits); end
        @(negedge clk); #1;
        checks++; if (bus_if.rd_valid !== 1'b0 || bus_if.stall !== 1'b0 || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL miss_done: got rv=%b stall=%b req=%b want 0/0/0", bus_if.rd_valid, bus_if.stall, bus_if.mem_req); end
    endtask

    task automatic test_write(input logic [15:0] addr, input logic [31:0] wd,
                              input logic [1:0] dt, input logic hit, input int delay);
        logic [1:0] exp_size;
        exp_size = (dt == 2'b11) ? 2'b00 : dt;
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.A = addr; bus_if.WD = wd;
        bus_if.dataType = dt; bus_if.cache_hit = hit;
        #1;
        checks++; if (bus_if.stall !== 1'b1) begin errors++; $display("FAIL write_stall_entry: got %b want 1", bus_if.stall); end
        for (int d = 0; d < delay; d++) begin
            @(negedge clk); #1;
            checks++; if (bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== (addr & 16'hFFFC)) begin errors++; $display("FAIL write_req: got req=%b we=%b addr=%h want 1/1/%h", bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, addr & 16'hFFFC); end
            checks++; if (bus_if.mem_wd !== wd || bus_if.mem_size !== exp_size) begin errors++; $display("FAIL write_data: got wd=%h size=%b want %h/%b", bus_if.mem_wd, bus_if.mem_size, wd, exp_size); end
            checks++; if (bus_if.upd_we !== 1'b0 || bus_if.stall !== 1'b1) begin errors++; $display("FAIL write_wait: got upd=%b stall=%b want 0/1", bus_if.upd_we, bus_if.stall); end
        end
        @(negedge clk);
        bus_if.mem_ack = 1'b1;
        #1;
        checks++; if (bus_if.upd_we !== hit || bus_if.mem_size !== exp_size) begin errors++; $display("FAIL write_ack: got upd=%b size=%b want %b/%b", bus_if.upd_we, bus_if.mem_size, hit, exp_size); end
        @(negedge clk);
        bus_if.mem_ack = 1'b0; bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.cache_hit = 1'b0;
        #1;
        checks++; if (bus_if.stall !== 1'b0 || bus_if.upd_we !== 1'b0 || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL write_done: got stall=%b upd=%b req=%b want 0/0/0", bus_if.stall, bus_if.upd_we, bus_if.mem_req); end
        checks++; if (bus_if.hit_cnt !== 16'(exp_hits) || bus_if.miss_cnt !== 16'(exp_misses) || bus_if.fill_we !== 1'b0) begin errors++; $display("FAIL write_no_alloc: got hits=%0d misses=%0d fill=%b want %0d/%0d/0", bus_if.hit_cnt, bus_if.miss_cnt, bus_if.fill_we, exp_hits, exp_misses); end
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.A = 16'($urandom); bus_if.cache_hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = $urandom;
        end
        @(negedge clk);
        bus_if.mem_rvalid = 1'b0; bus_if.req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        #1;
        checks++; if (bus_if.miss_cnt !== 16'h0 || bus_if.hit_cnt !== 16'h0) begin errors++; $display("FAIL rst_refill_cnt: got %0d/%0d want 0/0", bus_if.miss_cnt, bus_if.hit_cnt); end
        checks++; if (bus_if.stall !== 1'b0 || bus_if.mem_req !== 1'b0) begin errors++; $display("FAIL rst_refill_idle: got stall=%b req=%b want 0/0", bus_if.stall, bus_if.mem_req); end
        // Further stray beats must neither finish the aborted line nor write it.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = $urandom;
            #1;
            checks++; if (bus_if.fill_we !== 1'b0 || bus_if.mem_req !== 1'b0 || bus_if.stall !== 1'b0) begin errors++; $display("FAIL rst_refill_fill: got fill=%b req=%b stall=%b want 0/0/0", bus_if.fill_we, bus_if.mem_req, bus_if.stall); end
        end
        bus_if.mem_rvalid = 1'b0;
    endtask

    task automatic test_spurious_mem();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_if.mem_rvalid = 1'($urandom); bus_if.mem_ack = 1'b1; bus_if.mem_rdata = $urandom;
            bus_if.cache_hit = 1'b1;
            #1;
            checks++; if (bus_if.stall !== 1'b0 || bus_if.mem_req !== 1'b0 || bus_if.fill_we !== 1'b0 || bus_if.upd_we !== 1'b0 || bus_if.rd_valid !== 1'b0) begin errors++; $display("FAIL spurious_idle: got stall=%b req=%b fill=%b upd=%b rv=%b want all 0", bus_if.stall, bus_if.mem_req, bus_if.fill_we, bus_if.upd_we, bus_if.rd_valid); end
        end
        bus_if.mem_rvalid = 1'b0; bus_if.mem_ack = 1'b0; bus_if.cache_hit = 1'b0;
        test_read_hit(16'($urandom), $urandom);
    endtask

    task automatic test_random(input int iters);
        int op;
        for (int i = 0; i < iters; i++) begin
            op = $urandom_range(2, 0);
            case (op)
                0: test_read_hit(16'($urandom), $urandom);
                1: test_read_miss(16'($urandom), $urandom, $urandom, $urandom, $urandom, 2);
                default: test_write(16'($urandom), $urandom, 2'($urandom), 1'($urandom),
                                    $urandom_range(3, 0));
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_read_hit(16'h0100, 32'hDEADBEEF);
        test_read_miss(16'h1234, 32'h11, 32'h22, 32'h33, 32'h44, 0);
        test_read_miss(16'h123C, 32'h11, 32'h22, 32'h33, 32'h44, 1);
        test_write(16'h0040, 32'h000000AB, 2'b01, 1'b1, 3);
        test_write(16'h0042, 32'h0000BEEF, 2'b11, 1'b0, 1);
        test_reset_mid_refill();
        test_spurious_mem();
        test_random(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
